// File: rtl/ps2_rx_fifo_if.sv
// Host-side bundle for the PS/2 receiver: raw PS/2 pins, FIFO read port, status and sticky errors.
// slave is the receiver's view, master is the host's view.
interface ps2_rx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             ps2_clk_i;
    logic             ps2_din_i;
    logic             rd_en_i;
    logic             err_clr_i;
    logic [7:0]       dout_o;
    logic             empty_o;
    logic             full_o;
    logic [CNT_W-1:0] count_o;
    logic             busy_o;
    logic             parity_err_o;
    logic             frame_err_o;
    logic             overflow_o;

    modport master (
        output ps2_clk_i, ps2_din_i, rd_en_i, err_clr_i,
        input  dout_o, empty_o, full_o, count_o, busy_o,
        input  parity_err_o, frame_err_o, overflow_o
    );

    modport slave (
        input  ps2_clk_i, ps2_din_i, rd_en_i, err_clr_i,
        output dout_o, empty_o, full_o, count_o, busy_o,
        output parity_err_o, frame_err_o, overflow_o
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver: synchronise and glitch-filter the PS/2 clock, deframe
// 11-bit odd-parity frames, and queue good bytes in a show-ahead FIFO with sticky error flags.
module ps2_rx_fifo #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    ps2_rx_fifo_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic              clk_s1_q, clk_s2_q, din_s1_q, din_s2_q;
    logic [FCNT_W-1:0] flt_cnt_q;
    logic              flt_q, flt_prev_q;
    logic              fall;

    state_e            state_q;
    logic              busy_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic              par_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              parity_err_q, frame_err_q, overflow_q;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic frame_done, parity_ok, timeout, push, pop, push_ok, empty, full;
    logic set_par, set_frm, set_ovf;

    // Filtered level only follows the synchronised clock after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            din_s1_q   <= 1'b1;
            din_s2_q   <= 1'b1;
            flt_q      <= 1'b1;
            flt_prev_q <= 1'b1;
            flt_cnt_q  <= '0;
        end else begin
            clk_s1_q   <= bus.ps2_clk_i;
            clk_s2_q   <= clk_s1_q;
            din_s1_q   <= bus.ps2_din_i;
            din_s2_q   <= din_s1_q;
            flt_prev_q <= flt_q;
            if (clk_s2_q == flt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                flt_q     <= clk_s2_q;
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    assign fall       = flt_prev_q & ~flt_q;
    assign frame_done = fall && (state_q == StStop);
    assign parity_ok  = ^{shift_q, par_q};
    assign timeout    = (state_q != StIdle) && !fall && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign push       = frame_done && parity_ok && din_s2_q;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop     = bus.rd_en_i && !empty;
    assign push_ok = push && (!full || pop);

    assign set_par = frame_done && !parity_ok;
    assign set_frm = (frame_done && !din_s2_q) || timeout;
    assign set_ovf = push && full && !pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            // A new error in the clear cycle keeps its flag set.
            parity_err_q <= set_par | (parity_err_q & ~bus.err_clr_i);
            frame_err_q  <= set_frm | (frame_err_q & ~bus.err_clr_i);
            overflow_q   <= set_ovf | (overflow_q & ~bus.err_clr_i);

            if (state_q == StIdle || fall) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            if (timeout) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else if (fall) begin
                unique case (state_q)
                    StIdle: begin
                        if (!din_s2_q) begin
                            state_q   <= StData;
                            busy_q    <= 1'b1;
                            bit_cnt_q <= '0;
                        end
                    end
                    StData: begin
                        shift_q   <= {din_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        par_q   <= din_s2_q;
                        state_q <= StStop;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; the head is masked to zero while empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign bus.dout_o       = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.empty_o      = empty;
    assign bus.full_o       = full;
    assign bus.count_o      = count_q;
    assign bus.busy_o       = busy_q;
    assign bus.parity_err_o = parity_err_q;
    assign bus.frame_err_o  = frame_err_q;
    assign bus.overflow_o   = overflow_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames are bit-banged on the PS/2 pins, a queue model
// predicts FIFO contents and flags, and a negedge monitor checks every read.
module tb_ps2_rx_fifo;
    localparam int unsigned FILTER_LEN     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 200;
    localparam int unsigned DEPTH          = 8;
    localparam int          HALF           = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_rx_fifo #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    bit         exp_par, exp_frm, exp_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".count"}, 32'(bus.count_o), 32'(exp_q.size()));
        chk({tag, ".empty"}, 32'(bus.empty_o), 32'(exp_q.size() == 0));
        chk({tag, ".full"}, 32'(bus.full_o), 32'(exp_q.size() == DEPTH));
        chk({tag, ".busy"}, 32'(bus.busy_o), 32'(0));
        chk({tag, ".parity_err"}, 32'(bus.parity_err_o), 32'(exp_par));
        chk({tag, ".frame_err"}, 32'(bus.frame_err_o), 32'(exp_frm));
        chk({tag, ".overflow"}, 32'(bus.overflow_o), 32'(exp_ovf));
        if (exp_q.size() != 0) chk({tag, ".head"}, 32'(bus.dout_o), 32'(exp_q[0]));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".dout"}, 32'(bus.dout_o), 32'(0));
        check_status(tag);
    endtask

    // Monitor: every cycle the host reads, the head must match the model (or FIFO must be empty).
    always @(negedge clk) begin
        if (!rst && bus.rd_en_i) begin
            if (exp_q.size() == 0) begin
                chk("rd_when_empty", 32'(bus.empty_o), 32'(1));
            end else begin
                chk("rd_data", 32'(bus.dout_o), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    // nbits < 11 abandons the frame after that many bits with the clock left high.
    task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit stop,
                              input int nbits, input bit glitch, input bit pop_at_stop);
        logic [10:0] bits;
        int          g;
        int          ones;
        bits = {stop, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_din_i = bits[i];
            cyc(10);
            bus.ps2_clk_i = 1'b0;
            if (pop_at_stop && i == 10) begin
                // Pin fall to edge pulse is 6 cycles; hold rd_en only for the stop-edge cycle.
                cyc(6);
                bus.rd_en_i = 1'b1;
                cyc(1);
                bus.rd_en_i = 1'b0;
                cyc(HALF - 7);
            end else if (glitch) begin
                g = $urandom_range(1, 3);
                cyc(15);
                bus.ps2_clk_i = 1'b1;
                cyc(g);
                bus.ps2_clk_i = 1'b0;
                cyc(25 - g);
            end else begin
                cyc(HALF);
            end
            bus.ps2_clk_i = 1'b1;
            if (glitch) begin
                g = $urandom_range(1, 3);
                cyc(10);
                bus.ps2_clk_i = 1'b0;
                cyc(g);
                bus.ps2_clk_i = 1'b1;
                cyc(20 - g);
            end else begin
                cyc(30);
            end
        end
        bus.ps2_din_i = 1'b1;
        if (nbits == 11) begin
            ones = $countones(data) + int'(bits[9]);
            if (ones % 2 == 0) exp_par = 1'b1;
            if (!stop) exp_frm = 1'b1;
            if (ones % 2 == 1 && stop) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(data);
                else exp_ovf = 1'b1;
            end
        end
        cyc(20);
    endtask

    task automatic read_n(input int n);
        bus.rd_en_i = 1'b1;
        cyc(n);
        bus.rd_en_i = 1'b0;
        cyc(1);
    endtask

    task automatic err_clear();
        bus.err_clr_i = 1'b1;
        cyc(1);
        bus.err_clr_i = 1'b0;
        exp_par = 1'b0;
        exp_frm = 1'b0;
        exp_ovf = 1'b0;
        cyc(1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ps2_clk_i = 1'b1;
        bus.ps2_din_i = 1'b1;
        bus.rd_en_i   = 1'b0;
        bus.err_clr_i = 1'b0;
        rst           = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check_reset_values("reset");

        // Single good frame, then read it back.
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        check_status("v1");
        read_n(1);
        check_status("v1_read");

        // Wrong parity: flag set, nothing queued; clear it.
        send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        check_status("v2");
        err_clear();
        check_status("v2_clr");

        // Nine frames without reads: last one overflows.
        for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b0, 1'b1, 11, 1'b0, 1'b0);
        check_status("v3");
        err_clear();
        check_status("v3_clr");

        // Full FIFO, pop on the stop-edge cycle: push and pop both happen.
        send_frame(8'h77, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        check_status("v6");
        read_n(9);
        check_status("v6_drain");

        // Partial frame then idle clock: timeout.
        send_frame(8'h00, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        chk("v4.busy_mid", 32'(bus.busy_o), 32'(1));
        cyc(600);
        exp_frm = 1'b1;
        check_status("v4");
        err_clear();
        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        check_status("v4_next");
        read_n(1);

        // Glitchy clock, then reset in the middle of a frame.
        send_frame(8'h29, 1'b0, 1'b1, 11, 1'b1, 1'b0);
        check_status("v5_glitch");
        send_frame(8'hA5, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        exp_q.delete();
        exp_par = 1'b0;
        exp_frm = 1'b0;
        exp_ovf = 1'b0;
        cyc(1);
        check_reset_values("v5_reset");
        cyc(300);
        check_reset_values("v5_after");

        // Randomized frames, reads and clears.
        for (int it = 0; it < 12; it++) begin
            send_frame(8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0),
                       11, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 2) == 0) read_n($urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) err_clear();
            check_status("rand");
        end
        read_n(DEPTH + 1);
        check_status("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal samples of synchronised PS/2 clock needed to change its filtered level.
REQ-002 Parameter TIMEOUT_CYCLES, default 5000: idle clk_i cycles allowed between falling edges inside a frame (100 us at 50 MHz).
REQ-003 Parameter FIFO_DEPTH, default 8: received-byte FIFO depth; power of two.
REQ-004 clk_i  input  1  single system clock (CPU clock domain); all logic rising-edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 ps2_clk_i  input  1  raw asynchronous PS/2 clock pin.
REQ-007 ps2_din_i  input  1  raw asynchronous PS/2 data pin.
REQ-008 rd_en_i  input  1  pop FIFO head this cycle.
REQ-009 err_clr_i  input  1  clear all sticky error flags.
REQ-010 dout_o  output  8  FIFO head byte (show-ahead); valid while empty_o=0.
REQ-011 empty_o  output  1  FIFO empty.
REQ-012 full_o  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-013 count_o  output  log2(FIFO_DEPTH)+1  bytes held.
REQ-014 busy_o  output  1  frame reception in progress (state not IDLE).
REQ-015 parity_err_o  output  1  sticky: frame failed odd-parity check.
REQ-016 frame_err_o  output  1  sticky: stop bit 0 or inter-edge timeout.
REQ-017 overflow_o  output  1  sticky: valid byte dropped because FIFO full.

Function
REQ-018 ps2_clk_i and ps2_din_i SHALL each pass a 2-flop synchroniser before any use.
REQ-019 Filtered clock SHALL change level only after FILTER_LEN consecutive identical synchronised samples; filtered level resets to 1.
REQ-020 Falling edge event SHALL be a single-cycle pulse when filtered clock goes 1->0; data bit sampled is the synchronised data in that cycle.
REQ-021 FSM states: IDLE, DATA, PARITY, STOP.
REQ-022 IDLE: edge with data=0 -> DATA, bit counter cleared; edge with data=1 ignored, stay IDLE.
REQ-023 DATA: each edge shifts bit in LSB-first; after 8th bit -> PARITY.
REQ-024 PARITY: edge captures parity bit -> STOP.
REQ-025 STOP: edge evaluates frame -> IDLE unconditionally.
REQ-026 Odd parity: data bits plus parity bit SHALL contain an odd number of ones; otherwise set parity_err_o and discard byte.
REQ-027 Stop bit 0 SHALL set frame_err_o and discard byte; if parity also bad, both flags set.
REQ-028 Timeout counter clears on every edge and in IDLE; reaching TIMEOUT_CYCLES in DATA/PARITY/STOP SHALL set frame_err_o, discard partial byte, return to IDLE.
REQ-029 Good frame: byte pushed in the stop-edge cycle E; empty_o low and dout_o valid at E+1 when FIFO was empty.
REQ-030 Push while full and rd_en_i=0: byte dropped, overflow_o set, FIFO contents unchanged.
REQ-031 Push and pop same cycle: both SHALL occur (including when full); count_o unchanged.
REQ-032 rd_en_i while empty SHALL be ignored; no pointer or count change, no error flag.
REQ-033 Pop SHALL advance head next cycle; pointers wrap modulo FIFO_DEPTH.
REQ-034 err_clr_i clears flags next cycle; an error event in the same cycle SHALL win (flag stays set).
REQ-035 busy_o SHALL be 1 exactly when FSM is not IDLE.

Reset
REQ-036 rst_i SHALL, at any time including mid-frame: FSM IDLE, shift/bit/timeout counters 0, synchronisers and filtered clock 1, FIFO empty.
REQ-037 Outputs after reset: dout_o 0x00, empty_o 1, full_o 0, count_o 0, busy_o 0, all error flags 0.
REQ-038 A frame interrupted by reset SHALL produce no push and no error flag.

Verification
V1 Frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz -> empty_o 0, dout_o 0x1C, count_o 1, no flags.
V2 Frame 0xF0 with parity 0 (wrong) -> parity_err_o 1, empty_o stays 1; err_clr_i pulse -> parity_err_o 0.
V3 Nine frames 0x01..0x09, no reads -> full_o 1 after 8, 0x09 dropped, overflow_o 1; 8 pops return 0x01..0x08, then empty_o 1.
V4 Start + 4 data bits, then clock held high 6000 cycles -> frame_err_o 1, busy_o 0, no push; next good frame 0x5A received correctly.
V5 1-3 cycle glitches on ps2_clk_i during frame 0x29 -> byte 0x29 received, no flags; reset asserted mid-frame -> all outputs at reset values, no push.
V6 FIFO full, pop asserted on stop-edge cycle of frame 0x77 -> count_o stays 8, overflow_o 0, 0x77 last out.
